// File: rtl/i2c_master_ctrl_pkg.sv
// Shared types and constants for the single-transaction I2C register master.
// Quarter-count constants give expected command-to-done latency for an unstretched bus.
package i2c_master_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StStart   = 3'd1,
        StTxByte  = 3'd2,
        StRxAck   = 3'd3,
        StRestart = 3'd4,
        StRxByte  = 3'd5,
        StTxNack  = 3'd6,
        StStop    = 3'd7
    } i2c_state_e;

    // Which byte of the transaction the current TX_BYTE/RX_ACK pair belongs to
    typedef enum logic [1:0] {
        ByteAddr = 2'd0,
        ByteReg  = 2'd1,
        ByteLast = 2'd2
    } byte_sel_e;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam int unsigned WR_QUARTERS   = 116;
    localparam int unsigned RD_QUARTERS   = 156;
    localparam int unsigned NACK_QUARTERS = 44;

    function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic rw);
        return {dev, rw};
    endfunction

endpackage

// File: rtl/i2c_qtr_tick.sv
// SCL quarter-period tick generator. A stall holds the counter at its terminal count,
// so a clock-stretching slave delays the next tick by exactly the stretch length.
module i2c_qtr_tick #(
    parameter int unsigned QTR_CNT   = 125,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic run_i,
    input  logic stall_i,
    output logic tick_o
);

    localparam logic [CNT_WIDTH-1:0] Reload = CNT_WIDTH'(QTR_CNT - 1);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (load_i) begin
            cnt_d = Reload;
        end else if (run_i) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
            end else if (!stall_i) begin
                tick_o = 1'b1;
                cnt_d  = Reload;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/io_deglitch.sv
// Two-flop synchroniser for an open-drain bus line; the output only follows once both
// stages agree, so a single-clock glitch never reaches the controller. Idles high.
module io_deglitch (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, sync_q, out_q, out_d;

    always_comb begin
        out_d = (meta_q == sync_q) ? sync_q : out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            out_q  <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            out_q  <= out_d;
        end
    end

    assign q_o = out_q;

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-transaction I2C master: register write or register read (with repeated start)
// toward a 7-bit-address slave, open-drain pins, slave clock stretching honoured.
module i2c_master_ctrl
    import i2c_master_ctrl_pkg::*;
#(
    parameter int unsigned QTR_CNT   = 125,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       nack,
    inout  wire        SCL,
    inout  wire        SDA
);

    logic rst_n;
    assign rst_n = RST;

    i2c_state_e state_q, state_d;
    byte_sel_e  sel_q, sel_d;
    logic [1:0] qtr_q, qtr_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       ack_q, ack_d;
    logic       rw_q, rw_d;
    logic [6:0] dev_q, dev_d;
    logic [7:0] reg_q, reg_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       nack_q, nack_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic scl_s, sda_s, tick, load, stall;
    logic scl_low, sda_low;

    io_deglitch u_scl_in (.clk(clk), .rst_n(rst_n), .d_i(SCL), .q_o(scl_s));
    io_deglitch u_sda_in (.clk(clk), .rst_n(rst_n), .d_i(SDA), .q_o(sda_s));

    // Only the q1->q2 boundary waits for SCL to be seen high
    assign stall = (qtr_q == Q1) && !scl_s;

    i2c_qtr_tick #(
        .QTR_CNT  (QTR_CNT),
        .CNT_WIDTH(CNT_WIDTH)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .run_i  (busy_q),
        .stall_i(stall),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ack_d   = ack_q;
        rw_d    = rw_q;
        dev_d   = dev_q;
        reg_d   = reg_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        nack_d  = nack_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;
        if (state_q == StIdle) begin
            if (start) begin
                load    = 1'b1;
                state_d = StStart;
                qtr_d   = Q0;
                busy_d  = 1'b1;
                nack_d  = 1'b0;
                rw_d    = rw;
                dev_d   = dev_addr;
                reg_d   = reg_addr;
                wdata_d = wdata;
            end
        end else if (tick) begin
            qtr_d = qtr_q + 2'd1;
            if (qtr_q == Q1) begin
                ack_d = sda_s;
                if (state_q == StRxByte) shift_d = {shift_q[6:0], sda_s};
            end
            if (qtr_q == Q3) begin
                unique case (state_q)
                    StStart: begin
                        state_d = StTxByte;
                        shift_d = addr_byte(dev_q, RW_WRITE);
                        bit_d   = 3'd0;
                        sel_d   = ByteAddr;
                    end
                    StRestart: begin
                        state_d = StTxByte;
                        shift_d = addr_byte(dev_q, RW_READ);
                        bit_d   = 3'd0;
                        sel_d   = ByteLast;
                    end
                    StTxByte: begin
                        shift_d = {shift_q[6:0], 1'b0};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = StRxAck;
                    end
                    StRxAck: begin
                        if (ack_q) begin
                            nack_d  = 1'b1;
                            state_d = StStop;
                        end else begin
                            unique case (sel_q)
                                ByteAddr: begin
                                    state_d = StTxByte;
                                    shift_d = reg_q;
                                    sel_d   = ByteReg;
                                end
                                ByteReg: begin
                                    if (rw_q == RW_READ) begin
                                        state_d = StRestart;
                                    end else begin
                                        state_d = StTxByte;
                                        shift_d = wdata_q;
                                        sel_d   = ByteLast;
                                    end
                                end
                                ByteLast: begin
                                    state_d = (rw_q == RW_READ) ? StRxByte : StStop;
                                end
                                default: state_d = StStop;
                            endcase
                        end
                    end
                    StRxByte: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            rdata_d = shift_q;
                            state_d = StTxNack;
                        end
                    end
                    StTxNack: state_d = StStop;
                    StStop: begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    always_comb begin
        scl_low = 1'b0;
        sda_low = 1'b0;
        unique case (state_q)
            StStart: begin
                scl_low = (qtr_q == Q3);
                sda_low = qtr_q[1];
            end
            // Pull SCL low in q0 so the slave can release its ACK before the repeated start
            StRestart: begin
                scl_low = (qtr_q == Q0) || (qtr_q == Q3);
                sda_low = qtr_q[1];
            end
            StTxByte: begin
                scl_low = (qtr_q == Q0);
                sda_low = ~shift_q[7];
            end
            StRxAck, StRxByte, StTxNack: scl_low = (qtr_q == Q0);
            StStop: begin
                scl_low = (qtr_q == Q0);
                sda_low = ~qtr_q[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sel_q   <= ByteAddr;
            qtr_q   <= Q0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            ack_q   <= 1'b1;
            rw_q    <= RW_WRITE;
            dev_q   <= 7'h00;
            reg_q   <= 8'h00;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            nack_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ack_q   <= ack_d;
            rw_q    <= rw_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            nack_q  <= nack_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign SCL   = scl_low ? 1'b0 : 1'bz;
    assign SDA   = sda_low ? 1'b0 : 1'bz;
    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign nack  = nack_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench: table of write/read/NACK/stretch transactions against a bus-level slave
// model at 7'h26, plus hand sequences for start-while-busy, back-to-back and mid-byte reset.
module tb_i2c_master_ctrl;
    import i2c_master_ctrl_pkg::*;

    localparam int unsigned QTR      = 4;
    localparam int          LIMIT    = 3000;
    localparam logic [6:0]  SLV_ADDR = 7'h26;
    localparam logic [7:0]  SLV_DATA = 8'h3C;

    logic       clk, rst_n, start, rw;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr, wdata, rdata;
    logic       busy, done, nack;
    wire        scl_w, sda_w;

    pullup (scl_w);
    pullup (sda_w);

    i2c_master_ctrl #(
        .QTR_CNT  (QTR),
        .CNT_WIDTH(8)
    ) dut (
        .clk     (clk),
        .RST     (rst_n),
        .start   (start),
        .rw      (rw),
        .dev_addr(dev_addr),
        .reg_addr(reg_addr),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .rdata   (rdata),
        .nack    (nack),
        .SCL     (scl_w),
        .SDA     (sda_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- slave model (samples the bus on the falling clk edge) ----------------
    typedef enum logic [2:0] {SIdle, SRx, SAck, STx, SMack, SIgn} slv_e;

    logic       slv_scl_low = 1'b0;
    logic       slv_sda_low = 1'b0;
    logic       stretch_en  = 1'b0;
    assign scl_w = slv_scl_low ? 1'b0 : 1'bz;
    assign sda_w = slv_sda_low ? 1'b0 : 1'bz;

    slv_e       s_st = SIdle;
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    logic [7:0] s_sh = 8'h00;
    int         s_bits = 0, s_nbyte = 0, stretch_cnt = 0;
    logic       s_first = 1'b0, s_match = 1'b0, s_rd = 1'b0, mack_bit = 1'b0;
    logic [7:0] log_mem [64];
    int         n_log = 0, n_start = 0, n_stop = 0;

    always @(negedge clk) begin
        logic scl_now, sda_now;
        scl_now = scl_w;
        sda_now = sda_w;
        if (stretch_cnt > 0) begin
            stretch_cnt = stretch_cnt - 1;
            if (stretch_cnt == 0) slv_scl_low = 1'b0;
        end
        if (prev_scl && scl_now && prev_sda && !sda_now) begin
            s_st = SRx; s_bits = 0; s_nbyte = 0; s_first = 1'b1; n_start++;
        end else if (prev_scl && scl_now && !prev_sda && sda_now) begin
            s_st = SIdle; n_stop++;
        end else if (!prev_scl && scl_now) begin
            case (s_st)
                SRx: begin s_sh = {s_sh[6:0], sda_now}; s_bits++; end
                STx: s_bits++;
                SMack: mack_bit = sda_now;
                default: ;
            endcase
        end else if (prev_scl && !scl_now) begin
            case (s_st)
                SRx: if (s_bits == 8) begin
                    if (n_log < 64) log_mem[n_log] = s_sh;
                    n_log++;
                    s_nbyte++;
                    if (s_first) begin
                        s_match = (s_sh[7:1] == SLV_ADDR);
                        s_rd    = s_sh[0];
                        s_first = 1'b0;
                    end
                    if (s_match) begin
                        slv_sda_low = 1'b1;
                        s_st = SAck;
                        // 4 clks to the master's own release plus 50 clks of real stretch
                        if (stretch_en && s_nbyte == 2) begin
                            slv_scl_low = 1'b1;
                            stretch_cnt = 54;
                        end
                    end else begin
                        s_st = SIgn;
                    end
                end
                SAck: begin
                    slv_sda_low = 1'b0;
                    s_bits = 0;
                    if (s_rd) begin
                        s_st = STx;
                        slv_sda_low = ~SLV_DATA[7];
                    end else begin
                        s_st = SRx;
                    end
                end
                STx: if (s_bits == 8) begin
                    slv_sda_low = 1'b0;
                    s_st = SMack;
                end else begin
                    slv_sda_low = ~SLV_DATA[7 - s_bits];
                end
                SMack: s_st = SIgn;
                default: ;
            endcase
        end
        prev_scl = scl_now;
        prev_sda = sda_now;
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic rw_v, input logic [6:0] dev_v, input logic [7:0] rg_v,
                         input logic [7:0] wd_v);
        rw = rw_v; dev_addr = dev_v; reg_addr = rg_v; wdata = wd_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    typedef struct {
        string      name;
        logic       rw;
        logic [6:0] dev;
        logic [7:0] rg;
        logic [7:0] wd;
        logic       stretch;
        int         cyc;
        logic       nack;
        logic [7:0] rdata;
        int         nbytes;
        int         nstarts;
        logic [7:0] b [3];
    } vec_t;

    vec_t vecs [4];

    initial begin
        int cyc, lb, sb, pb, ndone, first_done;

        vecs[0] = '{"write", RW_WRITE, 7'h26, 8'h02, 8'hA5, 1'b0, WR_QUARTERS * QTR,
                    1'b0, 8'h00, 3, 1, '{8'h4C, 8'h02, 8'hA5}};
        vecs[1] = '{"read", RW_READ, 7'h26, 8'h00, 8'h00, 1'b0, RD_QUARTERS * QTR,
                    1'b0, 8'h3C, 3, 2, '{8'h4C, 8'h00, 8'h4D}};
        vecs[2] = '{"nack", RW_WRITE, 7'h27, 8'h02, 8'hA5, 1'b0, NACK_QUARTERS * QTR,
                    1'b1, 8'h3C, 1, 1, '{8'h4E, 8'h00, 8'h00}};
        vecs[3] = '{"stretch", RW_WRITE, 7'h26, 8'h02, 8'hA5, 1'b1, WR_QUARTERS * QTR + 50,
                    1'b0, 8'h3C, 3, 1, '{8'h4C, 8'h02, 8'hA5}};

        rst_n = 1'b0; start = 1'b0; rw = 1'b0; dev_addr = '0; reg_addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset rdata", rdata, 0);
        chk("reset nack", nack, 0);
        chk("reset scl", scl_w, 1);
        chk("reset sda", sda_w, 1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            stretch_en = vecs[i].stretch;
            lb = n_log; sb = n_start; pb = n_stop;
            issue(vecs[i].rw, vecs[i].dev, vecs[i].rg, vecs[i].wd);
            chk({vecs[i].name, " busy"}, busy, 1);
            wait_done(cyc);
            chk({vecs[i].name, " latency"}, cyc, vecs[i].cyc);
            chk({vecs[i].name, " nack"}, nack, vecs[i].nack);
            chk({vecs[i].name, " rdata"}, rdata, vecs[i].rdata);
            @(negedge clk);
            chk({vecs[i].name, " done pulse"}, done, 0);
            chk({vecs[i].name, " busy end"}, busy, 0);
            repeat (4) @(negedge clk);
            chk({vecs[i].name, " bytes"}, n_log - lb, vecs[i].nbytes);
            chk({vecs[i].name, " starts"}, n_start - sb, vecs[i].nstarts);
            chk({vecs[i].name, " stops"}, n_stop - pb, 1);
            for (int k = 0; k < vecs[i].nbytes; k++)
                chk($sformatf("%s byte%0d", vecs[i].name, k), log_mem[lb + k], vecs[i].b[k]);
            if (vecs[i].rw == RW_READ) chk({vecs[i].name, " master nack"}, mack_bit, 1);
        end
        stretch_en = 1'b0;

        // start held while busy must not launch a second transaction
        lb = n_log; ndone = 0; first_done = -1;
        issue(RW_WRITE, 7'h26, 8'h02, 8'hA5);
        for (int i = 1; i <= 700; i++) begin
            @(negedge clk);
            if (i == 5) begin dev_addr = 7'h27; start = 1'b1; end
            if (i == 8) start = 1'b0;
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = i;
            end
        end
        chk("busy-start done count", ndone, 1);
        chk("busy-start latency", first_done, WR_QUARTERS * QTR);
        chk("busy-start bytes", n_log - lb, 3);
        chk("busy-start addr", log_mem[lb], 8'h4C);

        // a start issued while done is high is accepted immediately
        issue(RW_WRITE, 7'h26, 8'h10, 8'h5A);
        wait_done(cyc);
        lb = n_log;
        issue(RW_WRITE, 7'h26, 8'h11, 8'h3B);
        chk("b2b accepted", busy, 1);
        wait_done(cyc);
        chk("b2b latency", cyc, WR_QUARTERS * QTR);
        repeat (4) @(negedge clk);
        chk("b2b reg", log_mem[lb + 1], 8'h11);
        chk("b2b data", log_mem[lb + 2], 8'h3B);

        // reset in the second bit slot of the data byte (bit6 of A5 = 0 -> SDA low)
        issue(RW_WRITE, 7'h26, 8'h02, 8'hA5);
        cyc = 0;
        while (cyc < 321) begin @(negedge clk); cyc++; end
        chk("pre-reset scl", scl_w, 0);
        chk("pre-reset sda", sda_w, 0);
        chk("pre-reset busy", busy, 1);
        chk("pre-reset rdata", rdata, 8'h3C);
        rst_n = 1'b0;
        #1;
        chk("mid-reset scl", scl_w, 1);
        chk("mid-reset sda", sda_w, 1);
        chk("mid-reset busy", busy, 0);
        chk("mid-reset rdata", rdata, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        lb = n_log;
        issue(RW_WRITE, 7'h26, 8'h02, 8'hA5);
        wait_done(cyc);
        chk("post-reset latency", cyc, WR_QUARTERS * QTR);
        chk("post-reset nack", nack, 0);
        repeat (4) @(negedge clk);
        chk("post-reset bytes", n_log - lb, 3);
        chk("post-reset data", log_mem[lb + 2], 8'hA5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
